// File: rtl/omr_grader.sv
// omr_grader: grades one-hot OMR answer beats against a stored key with optional negative marking
module omr_grader #(
   parameter int NUM_Q = 10,
   parameter int ANS_W = 4,
   parameter int MARK_POS = 4,
   parameter int MARK_NEG = 1,
   localparam int CNT_W = $clog2(NUM_Q + 1),
   localparam int SCORE_W = $clog2(NUM_Q * MARK_POS + 1) + 1
)(
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      key_valid,
   input  logic [ANS_W-1:0]          key_data,
   input  logic                      start,
   input  logic                      neg_en,
   input  logic                      abort,
   input  logic                      ans_valid,
   input  logic [ANS_W-1:0]          ans_data,
   output logic                      ans_ready,
   output logic                      key_loaded,
   output logic                      done,
   output logic [CNT_W-1:0]          correct_cnt,
   output logic [CNT_W-1:0]          wrong_cnt,
   output logic [CNT_W-1:0]          blank_cnt,
   output logic signed [SCORE_W-1:0] score
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] GRADE = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   logic [1:0] state;
   logic [ANS_W-1:0] key [NUM_Q];
   logic [CNT_W-1:0] key_ptr, q_ptr, wptr;
   logic [ANS_W-1:0] key_cur;
   logic neg_l, onehot, is_correct, is_blank, is_wrong, wlast, qlast;
   always_comb begin
      key_cur = key[q_ptr];
      onehot = (ans_data != '0) && ((ans_data & (ans_data - ANS_W'(1))) == '0);
      is_correct = (key_cur == '0) || (onehot && |(ans_data & key_cur));
      is_blank = !is_correct && (ans_data == '0);
      is_wrong = !is_correct && !is_blank;
      wptr = key_loaded ? '0 : key_ptr;
      wlast = wptr == CNT_W'(NUM_Q - 1);
      qlast = q_ptr == CNT_W'(NUM_Q - 1);
   end
   assign ans_ready = state == GRADE;
   assign done = state == DONE;
   assign score = SCORE_W'(MARK_POS * int'(correct_cnt) - (neg_l ? MARK_NEG * int'(wrong_cnt) : 0));
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         key_ptr <= '0;
         q_ptr <= '0;
         key_loaded <= 1'b0;
         neg_l <= 1'b0;
         correct_cnt <= '0;
         wrong_cnt <= '0;
         blank_cnt <= '0;
         for (int i = 0; i < NUM_Q; i++) key[i] <= '0;
      end else if (state == IDLE) begin
         if (key_valid) begin
            key[wptr] <= key_data;
            key_loaded <= wlast;
            key_ptr <= wlast ? '0 : wptr + CNT_W'(1);
         end else if (start && key_loaded) begin
            state <= GRADE;
            q_ptr <= '0;
            neg_l <= neg_en;
            correct_cnt <= '0;
            wrong_cnt <= '0;
            blank_cnt <= '0;
         end
      end else if (abort) begin
         state <= IDLE;
         q_ptr <= '0;
         correct_cnt <= '0;
         wrong_cnt <= '0;
         blank_cnt <= '0;
      end else if (state == GRADE) begin
         if (ans_valid) begin
            correct_cnt <= correct_cnt + CNT_W'(is_correct);
            wrong_cnt <= wrong_cnt + CNT_W'(is_wrong);
            blank_cnt <= blank_cnt + CNT_W'(is_blank);
            q_ptr <= qlast ? '0 : q_ptr + CNT_W'(1);
            if (qlast) state <= DONE;
         end
      end else if (start) begin
         state <= GRADE;
         q_ptr <= '0;
         neg_l <= neg_en;
         correct_cnt <= '0;
         wrong_cnt <= '0;
         blank_cnt <= '0;
      end
   end
endmodule

// File: tb/tb_omr_grader.sv
// tb_omr_grader: directed checks of omr_grader with hand-computed tallies and scores
module tb_omr_grader;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic key_valid = 1'b0, start = 1'b0, neg_en = 1'b0, abort = 1'b0, ans_valid = 1'b0;
   logic [3:0] key_data = '0, ans_data = '0;
   logic ans_ready, key_loaded, done;
   logic [3:0] correct_cnt, wrong_cnt, blank_cnt;
   logic signed [6:0] score;
   logic [3:0] key_m [10];
   logic [3:0] stu [10];
   int checks = 0, errors = 0;
   omr_grader dut (
      .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_data(key_data),
      .start(start), .neg_en(neg_en), .abort(abort), .ans_valid(ans_valid),
      .ans_data(ans_data), .ans_ready(ans_ready), .key_loaded(key_loaded), .done(done),
      .correct_cnt(correct_cnt), .wrong_cnt(wrong_cnt), .blank_cnt(blank_cnt), .score(score)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk_res(input string tag, input int c, input int w, input int b, input int s);
      chk({tag, " correct"}, int'(correct_cnt), c);
      chk({tag, " wrong"}, int'(wrong_cnt), w);
      chk({tag, " blank"}, int'(blank_cnt), b);
      chk({tag, " score"}, int'(score), s);
   endtask
   task automatic load_key();
      for (int i = 0; i < 10; i++) begin
         key_valid = 1'b1;
         key_data = key_m[i];
         tick();
         if (i == 8) begin
            key_valid = 1'b0;
            chk("key_loaded before last write", int'(key_loaded), 0);
         end
      end
      key_valid = 1'b0;
      chk("key_loaded after 10 writes", int'(key_loaded), 1);
   endtask
   task automatic run_sheet(input string tag, input logic neg, input bit gap, input bit noise);
      start = 1'b1;
      neg_en = neg;
      tick();
      start = 1'b0;
      neg_en = ~neg;
      chk({tag, " ans_ready in GRADE"}, int'(ans_ready), 1);
      for (int i = 0; i < 10; i++) begin
         key_valid = noise;
         key_data = 4'b0000;
         ans_valid = 1'b1;
         ans_data = stu[i];
         tick();
         if (gap) begin
            ans_valid = 1'b0;
            ans_data = 4'b0000;
            tick();
            tick();
         end
         if (i < 9) chk({tag, " done early"}, int'(done), 0);
      end
      ans_valid = 1'b0;
      key_valid = 1'b0;
      chk({tag, " done"}, int'(done), 1);
      chk({tag, " ans_ready off"}, int'(ans_ready), 0);
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, " done"}, int'(done), 0);
      chk({tag, " ans_ready"}, int'(ans_ready), 0);
      chk_res(tag, 0, 0, 0, 0);
   endtask
   initial begin
      #12;
      chk_zero("reset");
      chk("reset key_loaded", int'(key_loaded), 0);
      reset_n = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start without key", int'(ans_ready), 0);
      for (int i = 0; i < 10; i++) key_m[i] = 4'b0001;
      load_key();
      for (int i = 0; i < 10; i++) stu[i] = (i < 7) ? 4'b0001 : (i < 9) ? 4'b0010 : 4'b0000;
      run_sheet("sheetA", 1'b1, 1'b0, 1'b0);
      chk_res("sheetA", 7, 2, 1, 26);
      ans_valid = 1'b1;
      ans_data = 4'b0001;
      tick();
      tick();
      ans_valid = 1'b0;
      chk_res("DONE hold", 7, 2, 1, 26);
      run_sheet("sheetA gap", 1'b0, 1'b1, 1'b0);
      chk_res("sheetA gap", 7, 2, 1, 28);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_zero("abort DONE");
      chk("abort keeps key", int'(key_loaded), 1);
      for (int i = 0; i < 10; i++) stu[i] = 4'b0011;
      run_sheet("multi", 1'b1, 1'b0, 1'b1);
      chk_res("multi", 0, 10, 0, -10);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      key_m[3] = 4'b0000;
      for (int i = 0; i < 10; i++) begin
         key_valid = 1'b1;
         key_data = key_m[i];
         tick();
         key_valid = 1'b0;
         if (i == 0) chk("reload drops key_loaded", int'(key_loaded), 0);
         if (i == 4) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("start in reload gap", int'(ans_ready), 0);
         end
      end
      chk("reload key_loaded", int'(key_loaded), 1);
      for (int i = 0; i < 10; i++) stu[i] = 4'b0000;
      run_sheet("bonus", 1'b1, 1'b0, 1'b0);
      chk_res("bonus", 1, 0, 9, 4);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      for (int i = 0; i < 10; i++) stu[i] = 4'b0001;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         ans_valid = 1'b1;
         ans_data = stu[i];
         abort = (i == 9);
         tick();
      end
      ans_valid = 1'b0;
      abort = 1'b0;
      chk_zero("abort beat10");
      chk("abort beat10 key_loaded", int'(key_loaded), 1);
      tick();
      chk("abort beat10 no done", int'(done), 0);
      run_sheet("regrade", 1'b1, 1'b0, 1'b0);
      chk_res("regrade", 10, 0, 0, 40);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ans_valid = 1'b1;
         ans_data = 4'b0001;
         tick();
      end
      ans_valid = 1'b0;
      chk("pre-reset correct", int'(correct_cnt), 5);
      #2 reset_n = 1'b0;
      #1;
      chk_zero("async reset");
      chk("async reset key_loaded", int'(key_loaded), 0);
      tick();
      reset_n = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start after reset", int'(ans_ready), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
